mm_responder: RTL and testbench
===============================

Name: mm_responder

Overview:
- Handshaked main-memory responder for the ARC softcore. It closes the control-section `ack` loop that the flat memory leaves open.
- Accepts level-held `rd`/`wr` requests from microinstruction bits 19/18, inserts programmable wait states, then returns a one-cycle `ack` with read data.
- Sits between the datapath buses (`bus_a` address, `bus_b` write data) and the control section.

Parameters:
- ADDR_W, 10, word-address width; storage depth is 2**ADDR_W 32-bit words.
- WAIT_STATES, 2, extra cycles between request acceptance and `ack` (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; clock is `clk`, reset is asynchronous and active-high.
- rd  input  1  read request, level, held until `ack`.
- wr  input  1  write request, level, held until `ack`.
- address  input  32  byte address; word index = `address[ADDR_W+1:2]`, upper bits ignored (wrap).
- data_in  input  32  write data.
- data_out  output  32  read data, valid from `ack` cycle, held until next read completes.
- ack  output  1  one-cycle completion strobe to control section.
- busy  output  1  high while a request is in flight (BUSY or ACK state).
- err  output  1  misaligned access flag; only with feature enabled, else tied 0.

Behaviour:
- Reset values: `data_out`=0, `ack`=0, `busy`=0, `err`=0, state=IDLE, wait counter=0. Memory contents are not cleared by reset.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - If `rd|wr` is sampled high at a rising edge: latch word index, `data_in` and op; load counter=WAIT_STATES.
  - Go to BUSY if WAIT_STATES>0, else go to ACK.
  - `rd` and `wr` both high: write wins; no read is performed.
- BUSY: counter decrements each cycle; at counter==1 go to ACK. Changes on `rd`/`wr`/`address`/`data_in` are ignored (latched copies are used).
- Transition into ACK:
  - Write: latched data is committed to latched word.
  - Read: `data_out` is loaded from latched word.
- ACK: `ack`=1 for exactly one cycle, then IDLE.
- Back-to-back requests: IDLE may accept a new request on the cycle immediately after ACK.
- Latency: `ack` is asserted WAIT_STATES+1 cycles after the accepting edge. A WAIT_STATES=0 request accepted at edge N shows `ack` high in the cycle following edge N.
- Read-after-write to the same word in consecutive transactions returns the new data.
- `busy` is 1 in BUSY and ACK, else 0.
- Reset mid-operation: the FSM returns to IDLE immediately and no `ack` is issued. A write not yet committed (reset before entering ACK) is discarded. `data_out` clears to 0.
- Address wrap: word index ADDR_W bits wide; address 0x1000 with ADDR_W=10 maps to word 0.
- `data_out` is unchanged by writes and by idle cycles.

Optional Feature:
- Macro: MM_ALIGN_CHECK_EN.
- Enabled, request latched with `address[1:0]`!=0:
  - Access is suppressed: no memory write, `data_out` unchanged.
  - `ack` still issued with normal latency.
  - `err`=1 during the ACK cycle only.
- Disabled: `address[1:0]` is ignored (access rounds down to word); `err` is constant 0.

Test Plan:
- Reset then idle 5 cycles -> `ack`=0, `busy`=0, `data_out`=0x00000000 throughout.
- WAIT_STATES=2: write 0xDEADBEEF to address 0x010, then read 0x010 -> each `ack` 3 cycles after acceptance; read `data_out`=0xDEADBEEF.
- WAIT_STATES=0: back-to-back reads of 0x000 and 0x004 (preloaded 0x11111111, 0x22222222) -> `ack` on consecutive alternating cycles; `data_out` 0x11111111 then 0x22222222.
- Address wrap with ADDR_W=10: write 0xCAFE0001 to 0x1000, read 0x000 -> 0xCAFE0001.
- Reset asserted during BUSY of a write of 0x12345678 to 0x020 (prior value 0xAAAAAAAA) -> no `ack`; subsequent read of 0x020 -> 0xAAAAAAAA.
- MM_ALIGN_CHECK_EN defined: write 0x55555555 to 0x022 -> `ack` with `err`=1 one cycle; read of 0x020 returns prior value. Undefined: same write lands in word 0x020, `err`=0.

Source files
------------

// File: rtl/mm_responder.sv
// Handshaked main-memory responder: level rd/wr requests, WAIT_STATES wait cycles, one-cycle ack.
// Optional misaligned-access detection is enabled by defining MM_ALIGN_CHECK_EN.
module mm_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic                wr_q;
  logic [31:0]         mem [2**ADDR_W];

  logic                req;
  logic                go_ack;
  logic [ADDR_W-1:0]   idx_c;
  logic [31:0]         wdata_c;
  logic                wr_c;
  logic                suppress;
  logic                unused_addr_bits;

  assign req  = rd | wr;
  assign busy = (state != IDLE);
  assign unused_addr_bits = ^{address[31:ADDR_W+2], address[1:0]};

  // In IDLE the live inputs are used so a zero-wait request commits on its accepting edge.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    idx_c   = idx_q;
    wdata_c = wdata_q;
    wr_c    = wr_q;
    go_ack  = 1'b0;
    case (state)
      IDLE: begin
        idx_c   = address[ADDR_W+1:2];
        wdata_c = data_in;
        wr_c    = wr;
        go_ack  = req && (WAIT_STATES == 0);
      end
      BUSY:    go_ack = (cnt == 4'd1);
      default: go_ack = 1'b0;
    endcase
  end

`ifdef MM_ALIGN_CHECK_EN
  logic mis_q;

  assign suppress = (state == IDLE) ? (address[1:0] != 2'b00) : mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mis_q <= 1'b0;
    else if (state == IDLE && req)
      mis_q <= (address[1:0] != 2'b00);
  end
`else
  assign suppress = 1'b0;
`endif

  // NOTE: storage is deliberately left out of reset so it maps onto plain RAM; reset only blocks the commit.
  always_ff @(posedge clk) begin
    if (!rst && go_ack && wr_c && !suppress)
      mem[idx_c] <= wdata_c;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      wr_q     <= 1'b0;
      data_out <= 32'd0;
      ack      <= 1'b0;
      err      <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= idx_c;
            wdata_q <= wdata_c;
            wr_q    <= wr_c;
            cnt     <= 4'(WAIT_STATES);
            state   <= (WAIT_STATES == 0) ? ACK : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (go_ack)
            state <= ACK;
        end
        default: state <= IDLE;
      endcase
      if (go_ack) begin
        ack <= 1'b1;
        err <= suppress;
        if (!wr_c && !suppress)
          data_out <= mem[idx_c];
      end
    end
  end

endmodule

// File: tb/tb_mm_responder.sv
// Self-checking bench for mm_responder: one instance with WAIT_STATES=2 and one with WAIT_STATES=0.
// Table-driven transactions feed a scoreboard queue; reset and alignment corners are hand-written.
module tb_mm_responder;

`ifdef MM_ALIGN_CHECK_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  typedef struct {
    int          inst;
    logic        w;
    logic        r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] din_s  [2];
  logic [31:0] dout_s [2];
  logic        ack_s  [2];
  logic        busy_s [2];
  logic        err_s  [2];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_inst = -1;
  int   last_ack = 0;
  exp_t sb[$];
  vec_t tbl[11];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mm_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .rst(rst), .rd(rd_s[0]), .wr(wr_s[0]), .address(addr_s[0]),
    .data_in(din_s[0]), .data_out(dout_s[0]), .ack(ack_s[0]), .busy(busy_s[0]), .err(err_s[0])
  );

  mm_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst), .rd(rd_s[1]), .wr(wr_s[1]), .address(addr_s[1]),
    .data_in(din_s[1]), .data_out(dout_s[1]), .ack(ack_s[1]), .busy(busy_s[1]), .err(err_s[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input int inst);
    return (inst == 0) ? 2 : 0;
  endfunction

  // Called on a falling edge; returns on the falling edge after the ack cycle.
  task automatic txn(input vec_t v);
    int   lat;
    int   ws;
    exp_t e;
    ws = ws_of(v.inst);
    rd_s[v.inst]   = v.r;
    wr_s[v.inst]   = v.w;
    addr_s[v.inst] = v.addr;
    din_s[v.inst]  = v.wdata;
    sb.push_back('{d: v.exp_d, e: v.exp_e, lat: ws + 1});
    lat = 0;
    while (busy_s[v.inst] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("idle_before_request", 32'(busy_s[v.inst]), 32'd0);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      // Latched copies must be used once the request is accepted.
      addr_s[v.inst] = ~v.addr;
      din_s[v.inst]  = ~v.wdata;
    end while (!ack_s[v.inst] && lat < 40);
    rd_s[v.inst] = 1'b0;
    wr_s[v.inst] = 1'b0;
    e = sb.pop_front();
    check("ack_seen", 32'(ack_s[v.inst]), 32'd1);
    check("ack_latency", lat, e.lat);
    check("data_out", dout_s[v.inst], e.d);
    check("err_in_ack", 32'(err_s[v.inst]), 32'(e.e));
    check("busy_in_ack", 32'(busy_s[v.inst]), 32'd1);
    if (last_inst == v.inst)
      check("b2b_ack_gap", cyc - last_ack, ws + 2);
    last_inst = v.inst;
    last_ack  = cyc;
    @(negedge clk);
    check("ack_one_cycle", 32'(ack_s[v.inst]), 32'd0);
    check("err_one_cycle", 32'(err_s[v.inst]), 32'd0);
    check("data_out_held", dout_s[v.inst], e.d);
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 2; i++) begin
      rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 32'd0; din_s[i] = 32'd0;
    end

    tbl[0]  = '{inst: 0, w: 1, r: 0, addr: 32'h010,  wdata: 32'hDEADBEEF, exp_d: 32'h00000000, exp_e: 0};
    tbl[1]  = '{inst: 0, w: 0, r: 1, addr: 32'h010,  wdata: 32'h0,        exp_d: 32'hDEADBEEF, exp_e: 0};
    tbl[2]  = '{inst: 0, w: 1, r: 0, addr: 32'h1000, wdata: 32'hCAFE0001, exp_d: 32'hDEADBEEF, exp_e: 0};
    tbl[3]  = '{inst: 0, w: 0, r: 1, addr: 32'h000,  wdata: 32'h0,        exp_d: 32'hCAFE0001, exp_e: 0};
    tbl[4]  = '{inst: 0, w: 1, r: 1, addr: 32'h010,  wdata: 32'h0BADF00D, exp_d: 32'hCAFE0001, exp_e: 0};
    tbl[5]  = '{inst: 0, w: 0, r: 1, addr: 32'h010,  wdata: 32'h0,        exp_d: 32'h0BADF00D, exp_e: 0};
    tbl[6]  = '{inst: 0, w: 1, r: 0, addr: 32'h020,  wdata: 32'hAAAAAAAA, exp_d: 32'h0BADF00D, exp_e: 0};
    tbl[7]  = '{inst: 1, w: 1, r: 0, addr: 32'h000,  wdata: 32'h11111111, exp_d: 32'h00000000, exp_e: 0};
    tbl[8]  = '{inst: 1, w: 1, r: 0, addr: 32'h004,  wdata: 32'h22222222, exp_d: 32'h00000000, exp_e: 0};
    tbl[9]  = '{inst: 1, w: 0, r: 1, addr: 32'h000,  wdata: 32'h0,        exp_d: 32'h11111111, exp_e: 0};
    tbl[10] = '{inst: 1, w: 0, r: 1, addr: 32'h004,  wdata: 32'h0,        exp_d: 32'h22222222, exp_e: 0};

    // Reset, then five idle cycles with nothing happening.
    repeat (2) @(negedge clk);
    check("rst_data_out", dout_s[0], 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("idle_ack", 32'(ack_s[i]), 32'd0);
        check("idle_busy", 32'(busy_s[i]), 32'd0);
        check("idle_data_out", dout_s[i], 32'd0);
        check("idle_err", 32'(err_s[i]), 32'd0);
      end
    end

    for (int i = 0; i < 11; i++)
      txn(tbl[i]);

    // Misaligned write: suppressed with err when the check is built in, else rounds down.
    last_inst = -1;
    v = '{inst: 0, w: 1, r: 0, addr: 32'h022, wdata: 32'h55555555, exp_d: 32'h0BADF00D, exp_e: ALIGN_EN};
    txn(v);
    v = '{inst: 0, w: 0, r: 1, addr: 32'h020, wdata: 32'h0,
          exp_d: ALIGN_EN ? 32'hAAAAAAAA : 32'h55555555, exp_e: 0};
    txn(v);
    v = '{inst: 0, w: 1, r: 0, addr: 32'h020, wdata: 32'hAAAAAAAA,
          exp_d: ALIGN_EN ? 32'hAAAAAAAA : 32'h55555555, exp_e: 0};
    txn(v);

    // Reset while a write sits in BUSY: no ack, write discarded, data_out cleared.
    wr_s[0] = 1'b1; addr_s[0] = 32'h020; din_s[0] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    check("busy_before_reset", 32'(busy_s[0]), 32'd1);
    rst = 1'b1;
    wr_s[0] = 1'b0;
    #1;
    check("reset_ack", 32'(ack_s[0]), 32'd0);
    check("reset_busy", 32'(busy_s[0]), 32'd0);
    check("reset_data_out", dout_s[0], 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_ack_in_reset", 32'(ack_s[0]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("no_ack_after_reset", 32'(ack_s[0]), 32'd0);
    last_inst = -1;
    v = '{inst: 0, w: 0, r: 1, addr: 32'h020, wdata: 32'h0, exp_d: 32'hAAAAAAAA, exp_e: 0};
    txn(v);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
